// File: rtl/npu_pool_pkg.sv
// ---------------------------------------------------------------------------
// npu_pool_pkg
//
// Definitions shared by the NPU pooling datapath: the max-pooling comparator
// tree and the max-unpooling stage.
//
// Token layout: a packed {index, data} word.
//   data  : bits [DATA_LSB +: data_width]
//   index : bits [INDEX_LSB +: index_width]
// The index field sits directly above the data field. INDEX_LSB is given for
// the default data width. Blocks that take their data width as a parameter
// use index_lsb() to find the index field.
//
// Unpooling FSM state encoding: IDLE=1'b0, EMIT=1'b1.
// ---------------------------------------------------------------------------
package npu_pool_pkg;

    // Default field widths of the pooling datapath.
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_INDEX_WIDTH = 16;

    // Field slice positions within an {index, data} token.
    localparam int DATA_LSB  = 0;
    localparam int INDEX_LSB = DATA_LSB + DEFAULT_DATA_WIDTH;

    // Index-field LSB for a token whose data field is data_width bits wide.
    function automatic int index_lsb(input int data_width);
        return DATA_LSB + data_width;
    endfunction

    // Unpooling FSM state encoding.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } unpool_state_e;

endpackage : npu_pool_pkg

// File: rtl/max_unpool.sv
// ---------------------------------------------------------------------------
// max_unpool
//
// Streaming max-unpooling stage. This is the inverse of the max-pooling
// comparator tree. Each accepted {index, data} token expands into one pooling
// window of Win_Size output beats. The beat whose position equals the token
// index carries the data value. Every other beat carries zero.
//
// Parameters
//   Data_Width   width of the data field (not interpreted, passed bit-exact)
//   Index_Width  width of the index field
//   Win_Size     beats per window, 2 .. 2**Index_Width
//
// Ports
//   clk, rst_n     clock and asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last
//                  token input (valid/ready). in_last marks the frame's last
//                  window.
//   out_valid/out_ready/out_data
//                  beat output (valid/ready)
//   out_win_last   final beat of a window
//   out_last       final beat of a frame's last window
//   idx_err        sticky flag. Set when a token's index is >= Win_Size.
//   err_clr        synchronous clear of idx_err. A simultaneous set wins.
//
// Behaviour
//   A token accepted on edge N makes its first beat valid after edge N.
//   When the final beat of a window is taken, the next token is accepted on
//   the same edge. Back-to-back windows therefore stream without a bubble.
//   in_ready depends combinationally on out_ready only in that case.
//   All outputs except in_ready are registered. They are precomputed from the
//   next-state values, so a stalled beat holds its outputs stable.
// ---------------------------------------------------------------------------
module max_unpool
    import npu_pool_pkg::*;
#(
    parameter int Data_Width  = 8,
    parameter int Index_Width = 16,
    parameter int Win_Size    = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [Index_Width+Data_Width-1:0] in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [Data_Width-1:0]             out_data,
    output logic                              out_win_last,
    output logic                              out_last,
    output logic                              idx_err,
    input  logic                              err_clr
);

    // -----------------------------------------------------------------------
    // Local constants
    // -----------------------------------------------------------------------
    localparam int POS_W   = $clog2(Win_Size);
    localparam int IDX_LSB = index_lsb(Data_Width);

    // Position of the final beat in a window.
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(Win_Size - 1);

    // Win_Size can be as large as 2**Index_Width, which does not fit in
    // Index_Width bits. The range check therefore uses one extra bit.
    localparam logic [Index_Width:0] WIN_SIZE_EXT = (Index_Width + 1)'(Win_Size);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    unpool_state_e           state_q,        state_d;
    logic [POS_W-1:0]        pos_q,          pos_d;
    logic [Index_Width-1:0]  idx_h_q,        idx_h_d;
    logic [Data_Width-1:0]   data_h_q,       data_h_d;
    logic                    last_h_q,       last_h_d;
    logic                    idx_err_q,      idx_err_d;
    logic                    out_valid_q,    out_valid_d;
    logic [Data_Width-1:0]   out_data_q,     out_data_d;
    logic                    out_win_last_q, out_win_last_d;
    logic                    out_last_q,     out_last_d;

    // -----------------------------------------------------------------------
    // Token field extraction
    // -----------------------------------------------------------------------
    logic [Index_Width-1:0] tok_idx;
    logic [Data_Width-1:0]  tok_data;
    logic                   tok_idx_bad;

    assign tok_idx  = in_data[IDX_LSB +: Index_Width];
    assign tok_data = in_data[DATA_LSB +: Data_Width];

    // Full-width comparison. An out-of-range index is never wrapped into the
    // window.
    assign tok_idx_bad = ({1'b0, tok_idx} >= WIN_SIZE_EXT);

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    logic pos_at_last;
    logic out_xfer;
    logic in_xfer;

    assign pos_at_last = (pos_q == POS_LAST);
    assign out_xfer    = out_valid_q && out_ready;

    // The stage takes a new token when idle, or on the edge that consumes the
    // final beat of the current window.
    assign in_ready = (state_q == IDLE) || (out_xfer && pos_at_last);
    assign in_xfer  = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        idx_h_d   = idx_h_q;
        data_h_d  = data_h_q;
        last_h_d  = last_h_q;
        idx_err_d = idx_err_q;

        if (in_xfer) begin
            // This covers a token accepted in IDLE and a reload on the final
            // beat of a window.
            idx_h_d  = tok_idx;
            data_h_d = tok_data;
            last_h_d = in_last;
            pos_d    = '0;
            state_d  = EMIT;
        end else if (out_xfer) begin
            if (pos_at_last) begin
                state_d = IDLE;
            end else begin
                pos_d = pos_q + POS_W'(1);
            end
        end

        // If a set and a clear happen on the same edge, the set wins.
        if (in_xfer && tok_idx_bad) begin
            idx_err_d = 1'b1;
        end else if (err_clr) begin
            idx_err_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Output precompute
    //
    // The outputs are computed from the next-state values and then
    // registered. The beat seen after an edge therefore matches the position
    // held in pos_q after that edge. For an out-of-range index, no position
    // ever matches, so the whole window is zero.
    // -----------------------------------------------------------------------
    logic emit_d;
    logic data_beat_d;

    always_comb begin
        emit_d         = (state_d == EMIT);
        data_beat_d    = emit_d && (Index_Width'(pos_d) == idx_h_d);
        out_valid_d    = emit_d;
        out_data_d     = data_beat_d ? data_h_d : '0;
        out_win_last_d = emit_d && (pos_d == POS_LAST);
        out_last_d     = emit_d && (pos_d == POS_LAST) && last_h_d;
    end

    // -----------------------------------------------------------------------
    // Registers
    //
    // Reset discards any window in progress and clears all outputs
    // immediately.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pos_q          <= '0;
            idx_h_q        <= '0;
            data_h_q       <= '0;
            last_h_q       <= 1'b0;
            idx_err_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_win_last_q <= 1'b0;
            out_last_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            idx_h_q        <= idx_h_d;
            data_h_q       <= data_h_d;
            last_h_q       <= last_h_d;
            idx_err_q      <= idx_err_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_win_last_q <= out_win_last_d;
            out_last_q     <= out_last_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_win_last = out_win_last_q;
    assign out_last     = out_last_q;
    assign idx_err      = idx_err_q;

endmodule : max_unpool

// File: tb/tb_max_unpool.sv
// ---------------------------------------------------------------------------
// tb_max_unpool
//
// Self-checking bench for max_unpool with the default parameters
// (Data_Width=8, Index_Width=16, Win_Size=4).
//
// The reference model keeps a queue of expected output beats. Each accepted
// token appends one whole window. Each consumed beat is removed from the
// front. A single model bit tracks the sticky error flag.
//
// Inputs are driven just after the falling edge. Outputs are checked 1 time
// unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_max_unpool;

    localparam int DW = 8;
    localparam int IW = 16;
    localparam int WS = 4;
    localparam int TW = IW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_win_last;
    logic          out_last;
    logic          idx_err;
    logic          err_clr;

    max_unpool #(
        .Data_Width  (DW),
        .Index_Width (IW),
        .Win_Size    (WS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_win_last (out_win_last),
        .out_last     (out_last),
        .idx_err      (idx_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          wl;
        logic          lst;
    } beat_t;

    beat_t exp_q[$];
    logic  err_m  = 1'b0;
    int    checks = 0;
    int    errors = 0;

    // Compares one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Appends the window that a token expands into: data at position idx,
    // zero elsewhere.
    task automatic push_window(input logic [TW-1:0] tok, input logic lst);
        logic [IW-1:0] idx;
        logic [DW-1:0] dat;
        beat_t         b;
        idx = tok[TW-1:DW];
        dat = tok[DW-1:0];
        for (int p = 0; p < WS; p++) begin
            b.data = (int'(idx) == p) ? dat : '0;
            b.wl   = (p == WS - 1);
            b.lst  = (p == WS - 1) && lst;
            exp_q.push_back(b);
        end
    endtask

    // Runs one clock cycle. The task starts at a falling edge: it drives the
    // inputs, checks the outputs, crosses the rising edge, updates the model,
    // and returns at the next falling edge.
    task automatic step(input logic iv, input logic [TW-1:0] tok, input logic il,
                        input logic ordy, input logic ec, output logic acc);
        logic exp_rdy;
        logic out_x;
        in_valid  = iv;
        in_data   = tok;
        in_last   = il;
        out_ready = ordy;
        err_clr   = ec;
        #1;
        exp_rdy = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("in_ready", in_ready, exp_rdy);
        chk("idx_err", idx_err, err_m);
        if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_win_last", out_win_last, exp_q[0].wl);
            chk("out_last", out_last, exp_q[0].lst);
        end
        acc   = iv && exp_rdy;
        out_x = ordy && (exp_q.size() != 0);
        @(posedge clk);
        if (out_x) void'(exp_q.pop_front());
        if (acc) begin
            $display("accept token idx=%0d data=%02h last=%0b", tok[TW-1:DW], tok[DW-1:0], il);
            push_window(tok, il);
        end
        if (acc && (int'(tok[TW-1:DW]) >= WS)) err_m = 1'b1;
        else if (ec) err_m = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic          acc;
        int            n;
        logic [TW-1:0] tok;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_win_last", out_win_last, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_idx_err", idx_err, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Index 2, data 85
        step(1'b1, {16'd2, 8'h85}, 1'b0, 1'b1, 1'b0, acc);
        chk("t1_accept", acc, 1);
        repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Back-to-back windows. The second token is accepted on beat 4.
        step(1'b1, {16'd0, 8'h7F}, 1'b0, 1'b1, 1'b0, acc);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 10) begin
            step(1'b1, {16'd3, 8'h80}, 1'b0, 1'b1, 1'b0, acc);
            n++;
        end
        chk("t2_accept_cycle", n, 4);
        repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Stall at position 1 for three cycles.
        step(1'b1, {16'd1, 8'hAA}, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
        repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Out-of-range index, then clear, then set and clear together.
        step(1'b1, {16'd7, 8'h55}, 1'b0, 1'b1, 1'b0, acc);
        repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        chk("t4_err_cleared", idx_err, 0);
        step(1'b1, {16'd7, 8'h55}, 1'b0, 1'b1, 1'b1, acc);
        chk("t4_err_set_wins", idx_err, 1);
        repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Frame-last window
        step(1'b1, {16'd0, 8'h11}, 1'b1, 1'b1, 1'b0, acc);
        repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Reset asserted at position 2.
        step(1'b1, {16'd2, 8'h33}, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_data", out_data, 0);
        chk("t6_rst_out_win_last", out_win_last, 0);
        chk("t6_rst_idx_err", idx_err, 0);
        exp_q.delete();
        err_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, {16'd0, 8'h44}, 1'b0, 1'b1, 1'b0, acc);
        chk("t6_first_beat", out_data, 8'h44);
        repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tok = {16'($urandom_range(0, 5)), 8'($urandom)};
            step(1'($urandom_range(0, 1)), tok, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), acc);
        end
        repeat (12) step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        chk("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_max_unpool
